// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and helpers for the parametrised single-clock FIFO.
//   FIFO_STD / FIFO_FWFT : values for the FWFT read-mode parameter
//   cnt_width()          : bits needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Occupancy spans 0..depth inclusive, so one bit more than the address.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port storage array, WIDTH x DEPTH. Contents are not reset.
// Ports:
//   clk_i    : clock, rising edge
//   we_i     : write enable (synchronous write)
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address (asynchronous read)
//   rdata_o  : read data
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ADDR-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ADDR-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock parametrised FIFO with fill level, almost-full/almost-empty
// thresholds, selectable standard or first-word-fall-through read mode and a
// synchronous flush.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   flush            : synchronous clear of pointers, count and valid
//   wen, wdata       : write request and data
//   ren              : read request (pop in FWFT mode)
//   rdata, valid     : read data and its qualifier
//   full, empty      : count == DEPTH / count == 0
//   almost_full      : count >= AF_LEVEL
//   almost_empty     : count <= AE_LEVEL
//   count            : occupancy 0..DEPTH
//   overflow         : one-cycle pulse after a write attempted while full
//   underflow        : one-cycle pulse after a read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR     = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FIFO_STD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ADDR:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int            CW       = cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [ADDR:0] PTR_ONE  = (ADDR+1)'(1);

    // Pointers carry a wrap bit in the MSB; only the low ADDR bits address
    // the array. Occupancy is tracked by its own counter, not pointer math.
    logic [ADDR:0]    wptr_q, wptr_d;
    logic [ADDR:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic             ovf_q,  ovf_d;
    logic             unf_q,  unf_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Flags decode straight from the registered count.
    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == DEPTH_C);
    assign almost_full  = (cnt_q >= AF_C);
    assign almost_empty = (cnt_q <= AE_C);
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Full refuses a write even when a read is accepted in the same cycle,
    // and empty refuses a read even alongside a write (no write-through).
    assign wr_acc = wen & ~full  & ~flush;
    assign rd_acc = ren & ~empty & ~flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = wen & full  & ~flush;
        unf_d  = ren & empty & ~flush;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ADDR-1:0]),
        .wdata_i (wdata),
        .raddr_i (rptr_q[ADDR-1:0]),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; ren acts as the pop.
            assign rdata = mem_rdata;
            assign valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            logic             valid_q;

            // rd_acc is already low during flush, so valid drops and rdata
            // keeps its last value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= mem_rdata;
                    end
                end
            end

            assign rdata = rdata_q;
            assign valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata_s, rdata_f;
    logic       valid_s, valid_f, full_s, full_f, empty_s, empty_f;
    logic       af_s, af_f, ae_s, ae_f, ovf_s, ovf_f, unf_s, unf_f;
    logic [3:0] count_s, count_f;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata_s), .valid(valid_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata_f), .valid(valid_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a plain queue of words.
    logic [7:0] q[$];
    // Scoreboards: words expected out of the standard and FWFT instances.
    logic [7:0] exp_s[$];
    logic [7:0] exp_f[$];
    logic       e_ovf = 1'b0;
    logic       e_unf = 1'b0;
    logic       e_vs  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = q.size();
        chk("count_std",  32'(count_s), 32'(sz));
        chk("count_fwft", 32'(count_f), 32'(sz));
        chk("full_std",   32'(full_s),  32'(sz == D));
        chk("full_fwft",  32'(full_f),  32'(sz == D));
        chk("empty_std",  32'(empty_s), 32'(sz == 0));
        chk("empty_fwft", 32'(empty_f), 32'(sz == 0));
        chk("afull_std",  32'(af_s),    32'(sz >= 6));
        chk("afull_fwft", 32'(af_f),    32'(sz >= 6));
        chk("aempty_std", 32'(ae_s),    32'(sz <= 2));
        chk("aempty_fwft",32'(ae_f),    32'(sz <= 2));
        chk("ovf_std",    32'(ovf_s),   32'(e_ovf));
        chk("ovf_fwft",   32'(ovf_f),   32'(e_ovf));
        chk("unf_std",    32'(unf_s),   32'(e_unf));
        chk("unf_fwft",   32'(unf_f),   32'(e_unf));
        chk("valid_std",  32'(valid_s), 32'(e_vs));
        chk("valid_fwft", 32'(valid_f), 32'(sz > 0));
        if (sz > 0) chk("head_fwft", 32'(rdata_f), 32'(q[0]));
    endtask

    // Called at posedge+1: check current state, drive the next cycle's
    // inputs, advance the model by the FIFO rules, then wait one clock.
    task automatic step(input logic w, input logic r, input logic f, input logic [7:0] d);
        int sz;
        logic wacc, racc;
        logic [7:0] h;
        check_state();
        wen = w; ren = r; flush = f; wdata = d;
        sz    = q.size();
        wacc  = w && (sz < D) && !f;
        racc  = r && (sz > 0) && !f;
        e_ovf = w && (sz == D) && !f;
        e_unf = r && (sz == 0) && !f;
        e_vs  = racc;
        if (f) q.delete();
        if (racc) begin
            h = q.pop_front();
            exp_s.push_back(h);
            exp_f.push_back(h);
        end
        if (wacc) q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever an instance presents a word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_s) begin
                if (exp_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL std_unexpected: valid with data %0h, expected no word", rdata_s);
                end else begin
                    chk("std_rdata", 32'(rdata_s), 32'(exp_s.pop_front()));
                end
            end
            if (valid_f && ren && !flush) begin
                if (exp_f.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fwft_unexpected: pop with data %0h, expected no word", rdata_f);
                end else begin
                    chk("fwft_rdata", 32'(rdata_f), 32'(exp_f.pop_front()));
                end
            end
        end
    end

    initial begin
        int pw, pr;
        logic [7:0] d;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_rdata_std", 32'(rdata_s), 32'h0);

        // Fill to full, then one refused write.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain, then one read from empty.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Steady state at count 4 across pointer wraps.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

        // Single word into an empty FIFO, held without ren, then popped.
        step(1'b1, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Flush at count 5 together with wen and ren.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        step(1'b1, 1'b1, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-cycle at count 3.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count",  32'(count_s), 32'h0);
        chk("rst_empty",  32'(empty_s), 32'h1);
        chk("rst_full",   32'(full_s),  32'h0);
        chk("rst_aempty", 32'(ae_s),    32'h1);
        chk("rst_afull",  32'(af_s),    32'h0);
        chk("rst_valid_f",32'(valid_f), 32'h0);
        chk("rst_rdata_s",32'(rdata_s), 32'h0);
        q.delete(); exp_s.delete(); exp_f.delete();
        e_ovf = 1'b0; e_unf = 1'b0; e_vs = 1'b0;
        wen = 1'b0; ren = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic with varying write/read pressure.
        for (int blk = 0; blk < 12; blk++) begin
            pw = 20 + 30 * int'($urandom_range(2));
            pr = 20 + 30 * int'($urandom_range(2));
            for (int i = 0; i < 50; i++) begin
                d = 8'($urandom);
                step(int'($urandom_range(99)) < pw,
                     int'($urandom_range(99)) < pr,
                     int'($urandom_range(99)) < 2, d);
            end
        end

        // Drain and confirm every expected word came out.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("std_pending",  32'(exp_s.size()), 32'h0);
        chk("fwft_pending", 32'(exp_f.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO block.
- Adds configurable depth and width, a fill-level output, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and a synchronous flush.
- Sits between same-clock producer/consumer stages in datapaths that do not need a clock-domain crossing.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of entries; power of two, >=4
- ADDR, $clog2(DEPTH), address width; derived, not to be overridden
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL; range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous reset, active-low
- flush  input  1  synchronous clear of FIFO contents
- wen  input  1  write request
- wdata  input  WIDTH  write data
- ren  input  1  read request (pop/acknowledge in FWFT mode)
- rdata  output  WIDTH  read data
- valid  output  1  rdata holds a valid word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- almost_empty  output  1  count <= AE_LEVEL
- count  output  ADDR+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: write attempted while full
- underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, asynchronous):
  - wptr, rptr, count, rdata, valid, overflow, underflow all go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory array is not reset.
- Pointers:
  - ADDR+1 bits; the MSB is the wrap bit, and each pointer wraps naturally modulo 2*DEPTH.
  - count is a registered up/down counter, not derived from pointer subtraction.
- Flags:
  - All flags decode combinationally from registered count; no extra latency.
- Accept rules, evaluated on pre-edge state:
  - Write is accepted when wen && !full && !flush. It stores wdata at mem[wptr[ADDR-1:0]] and increments wptr.
  - Read is accepted when ren && !empty && !flush. It increments rptr.
  - When full, a write is refused even if a read is accepted in the same cycle.
  - When empty, a read is refused even if a write is accepted in the same cycle; no write-through.
- count update:
  - write only: +1
  - read only: -1
  - both or neither: unchanged
- Standard mode (FWFT=0):
  - On an accepted read, rdata <= head word; valid=1 on the next cycle for exactly one cycle per accepted read.
  - rdata holds its last value otherwise. Read latency is 1 clk.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr] combinationally whenever !empty; valid = !empty.
  - ren pops the word; the next word appears the cycle after the pop.
  - rdata is don't-care when valid=0.
  - Write-to-valid latency from empty is 1 clk, since count updates on the write edge.
- Error pulses:
  - overflow <= wen && full && !flush, registered, one cycle.
  - underflow <= ren && empty && !flush, registered, one cycle.
  - Refused operations leave the pointers, count and memory untouched.
- flush, synchronous:
  - At the next edge, wptr=rptr=count=0 and valid=0.
  - wen and ren in the same cycle are ignored; overflow and underflow are not raised.
  - rdata is unchanged.
- Wrap-around:
  - Correct full/empty detection after any number of pointer wraps; count alone is authoritative.
- Reset mid-operation:
  - Asynchronous clear overrides any in-flight write or read.
  - Words written before reset are inaccessible afterwards.

Decomposition:
- Package sync_fifo_pkg:
  - Mode constants FIFO_STD=0 and FIFO_FWFT=1.
  - Helper function for the count-width calculation.
- Sub-module sync_fifo_mem:
  - Simple dual-port array, WIDTH x DEPTH.
  - Synchronous write port and asynchronous read port.
- Top level holds the pointers, the counter, flag decode, read-mode muxing and error pulses.

Test Plan (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless stated):
- Reset, then write 0x11..0x18 over 8 cycles:
  - almost_empty clears after the 3rd write.
  - almost_full sets after the 6th write.
  - full=1 and count=8 after the 8th write.
  - A 9th write of 0xFF is refused and gives an overflow pulse the next cycle.
- From full, FWFT=0, read 8 times:
  - rdata 0x11..0x18 in order, each with valid one cycle after ren.
  - empty=1 at the end.
  - A 9th ren gives an underflow pulse and valid=0.
- Count 4, simultaneous wen+ren for 20 cycles with incrementing data:
  - count stays 4 and output order is preserved across pointer wraps.
- FWFT=1, write 0xA5 into an empty FIFO:
  - Next cycle valid=1 and rdata=0xA5 with no ren.
  - ren pops; valid=0 the following cycle.
- Count 5, assert flush together with wen and ren:
  - Next cycle count=0, empty=1, valid=0, no overflow or underflow pulse.
- Drive rst_n low mid-cycle with count 3:
  - Outputs clear immediately without waiting for clk.
  - After release, empty=1 and a read gives underflow.
